sopc_rst_ctrl: RTL and testbench
================================

// Module: sopc_rst_ctrl
// PURPOSE
//  Receives the board-level clock and reset that drive openmips_min_sopc and produces sequenced internal resets.
//  Synchronizes reset deassertion, then releases memories before the CPU.
//  Supports a software soft-reset and halt request, and counts run cycles.
//  Sits at the SOPC top, between the external clk/rst pins and the CPU/ROM/RAM reset inputs.
// PARAMETERS
//  RST_HOLD   4    cycles both resets stay asserted after the synchronizer releases (1..255)
//  MEM_LEAD   2    cycles mem_rst_o is low before cpu_rst_o goes low (1..255)
//  CNT_W      32   width of run_cycles_o
//  WDT_LIMIT  50   run-cycle count that fires the watchdog (used only with SOPC_RST_WDT_EN)
// PORTS
//  clk           in   1      system clock
//  rst           in   1      reset: asynchronous, active-high (`RstEnable = 1'b1)
//  soft_rst_i    in   1      1-cycle pulse: restart the sequence from HOLD
//  halt_req_i    in   1      level: request to halt the CPU while in RUN
//  mem_rst_o     out  1      active-high reset for inst_rom/data_ram
//  cpu_rst_o     out  1      active-high reset for the openmips core
//  cpu_stall_o   out  1      high in HALT; freezes the core pipeline
//  halted_o      out  1      high in HALT
//  wdt_fired_o   out  1      sticky; high once the watchdog has caused HALT
//  run_cycles_o  out  CNT_W  cycles spent in RUN since the last (soft) reset
//  state_o       out  3      current FSM state encoding
// BEHAVIOUR
//  - rst=1 (async): state=RESET; mem_rst_o=1, cpu_rst_o=1, cpu_stall_o=0, halted_o=0,
//    wdt_fired_o=0, run_cycles_o=0, sync flops=1. rst dominates every other input, in every state.
//  - Deassertion passes through a 2-flop synchronizer: sync_rst falls after the 2nd rising edge with rst=0.
//  - FSM states: RESET=0, HOLD=1, MEM_UP=2, RUN=3, HALT=4.
//    RESET -> HOLD when sync_rst=0. HOLD -> MEM_UP after RST_HOLD edges (counter cleared on entry).
//    MEM_UP -> RUN after MEM_LEAD edges. RUN -> HALT on halt_req_i or watchdog.
//    HALT -> HOLD only on soft_rst_i; halt_req_i is ignored there.
//  - Output registers:
//    mem_rst_o=1 in RESET and HOLD, 0 otherwise.
//    cpu_rst_o=1 in RESET, HOLD and MEM_UP, 0 in RUN and HALT.
//    Outputs are registered and change on the same edge as the state change.
//  - Timing, with edge k = k-th rising edge after rst falls:
//    mem_rst_o falls at edge 3+RST_HOLD; cpu_rst_o falls at edge 3+RST_HOLD+MEM_LEAD.
//  - run_cycles_o: +1 on every edge while in RUN; saturates at 2^CNT_W-1 and never wraps;
//    holds its value in HALT; cleared on entry to HOLD.
//  - soft_rst_i in any state other than RESET:
//    next state HOLD; mem_rst_o=cpu_rst_o=1; cpu_stall_o=halted_o=0;
//    run_cycles_o=0; wdt_fired_o cleared.
//  - Priority when inputs coincide: rst > soft_rst_i > watchdog > halt_req_i.
//    If halt_req_i and the watchdog both fire, go to HALT and set wdt_fired_o=1.
//  - In HALT: cpu_stall_o=halted_o=1; resets stay deasserted.
// CONFIGURATION
//  SOPC_RST_WDT_EN defined: in RUN, when run_cycles_o == WDT_LIMIT-1 at an edge,
//    next state is HALT with wdt_fired_o=1. run_cycles_o then reads WDT_LIMIT.
//  SOPC_RST_WDT_EN undefined: no watchdog logic; wdt_fired_o is tied 0;
//    the only ways into HALT are halt_req_i or the counter saturating.
// STRUCTURE
//  - Shared defines go in define.v: `RstEnable/`RstDisable, state encodings `RstSt*,
//    and the default RST_HOLD/MEM_LEAD values.
//  - Sub-module rst_sync: 2-flop async-assert/sync-deassert synchronizer, instanced once.
//  - The FSM, hold counter and run counter stay in sopc_rst_ctrl.
// TESTING
//  Clock period is 20 ns; rst released at 195 ns, as in the SOPC bench.
//  1. Power-up, defaults:
//     -> mem_rst_o falls at edge 7; cpu_rst_o falls at edge 9; state_o=3;
//     run_cycles_o=1 after edge 10.
//  2. rst pulsed high for 5 ns mid-RUN
//     -> all outputs at reset values immediately (async); full sequence repeats.
//  3. halt_req_i=1 at RUN cycle 20 -> halted_o=cpu_stall_o=1 next edge; run_cycles_o frozen at 20;
//     then soft_rst_i -> state_o=1, run_cycles_o=0, cpu_rst_o=1.
//  4. SOPC_RST_WDT_EN defined, WDT_LIMIT=50
//     -> HALT with wdt_fired_o=1 and run_cycles_o=50; without the macro, RUN continues past 50.
//  5. soft_rst_i and halt_req_i in the same RUN cycle -> state_o=1 (HOLD), halted_o=0.
//  6. CNT_W=4 without the watchdog -> run_cycles_o saturates at 15 and holds; no wrap to 0.

Source files
------------

// File: rtl/sopc_rst_ctrl_pkg.sv
// Shared reset-controller definitions: reset levels, FSM encodings and
// default sequencing lengths for the SOPC reset controller.
package sopc_rst_ctrl_pkg;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic RST_DISABLE = 1'b0;

    localparam int DEF_RST_HOLD = 4;
    localparam int DEF_MEM_LEAD = 2;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_HOLD   = 3'd1,
        ST_MEM_UP = 3'd2,
        ST_RUN    = 3'd3,
        ST_HALT   = 3'd4
    } rst_state_e;

endpackage

// File: rtl/sopc_rst_ctrl_rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases
// on the second rising edge after rst falls.
module rst_sync
    import sopc_rst_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic sync_rst
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            sync_q <= {2{RST_ENABLE}};
        end else begin
            sync_q <= {sync_q[0], RST_DISABLE};
        end
    end

    assign sync_rst = sync_q[1];

endmodule

// File: rtl/sopc_rst_ctrl.sv
// Sequenced SOPC reset controller: memories leave reset before the CPU.
// Optional watchdog halt enabled by defining SOPC_RST_WDT_EN.
module sopc_rst_ctrl
    import sopc_rst_ctrl_pkg::*;
#(
    parameter int RST_HOLD  = DEF_RST_HOLD,
    parameter int MEM_LEAD  = DEF_MEM_LEAD,
    parameter int CNT_W     = 32,
    parameter int WDT_LIMIT = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst_i,
    input  logic             halt_req_i,
    output logic             mem_rst_o,
    output logic             cpu_rst_o,
    output logic             cpu_stall_o,
    output logic             halted_o,
    output logic             wdt_fired_o,
    output logic [CNT_W-1:0] run_cycles_o,
    output logic [2:0]       state_o
);

`ifdef SOPC_RST_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    localparam logic [7:0]       HOLD_LAST = 8'(RST_HOLD - 1);
    localparam logic [7:0]       LEAD_LAST = 8'(MEM_LEAD - 1);
    localparam logic [CNT_W-1:0] RUN_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_LIMIT - 1);

    rst_state_e       state;
    logic [7:0]       seq_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic             sync_rst;
    logic             wdt_hit;
    logic             sat_hit;

    rst_sync u_rst_sync (
        .clk      (clk),
        .rst      (rst),
        .sync_rst (sync_rst)
    );

    // Halting on saturation keeps the count from ever wrapping.
    assign wdt_hit = WDT_ON && (run_cnt == WDT_LAST);
    assign sat_hit = (run_cnt == RUN_MAX - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state       <= ST_RESET;
            seq_cnt     <= '0;
            run_cnt     <= '0;
            mem_rst_o   <= RST_ENABLE;
            cpu_rst_o   <= RST_ENABLE;
            cpu_stall_o <= 1'b0;
            halted_o    <= 1'b0;
            wdt_fired_o <= 1'b0;
        end else if (soft_rst_i && state != ST_RESET) begin
            state       <= ST_HOLD;
            seq_cnt     <= '0;
            run_cnt     <= '0;
            mem_rst_o   <= RST_ENABLE;
            cpu_rst_o   <= RST_ENABLE;
            cpu_stall_o <= 1'b0;
            halted_o    <= 1'b0;
            wdt_fired_o <= 1'b0;
        end else begin
            unique case (state)
                ST_RESET: begin
                    if (sync_rst == RST_DISABLE) begin
                        state   <= ST_HOLD;
                        seq_cnt <= '0;
                        run_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (seq_cnt == HOLD_LAST) begin
                        state     <= ST_MEM_UP;
                        seq_cnt   <= '0;
                        mem_rst_o <= RST_DISABLE;
                    end else begin
                        seq_cnt <= seq_cnt + 8'd1;
                    end
                end
                ST_MEM_UP: begin
                    if (seq_cnt == LEAD_LAST) begin
                        state     <= ST_RUN;
                        seq_cnt   <= '0;
                        cpu_rst_o <= RST_DISABLE;
                    end else begin
                        seq_cnt <= seq_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (run_cnt != RUN_MAX) begin
                        run_cnt <= run_cnt + CNT_W'(1);
                    end
                    if (wdt_hit || sat_hit || halt_req_i) begin
                        state       <= ST_HALT;
                        cpu_stall_o <= 1'b1;
                        halted_o    <= 1'b1;
                    end
                    if (wdt_hit) begin
                        wdt_fired_o <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_RESET;
                end
            endcase
        end
    end

    assign run_cycles_o = run_cnt;
    assign state_o      = state;

endmodule

// File: tb/tb_sopc_rst_ctrl.sv
// Scoreboard bench for sopc_rst_ctrl; reference model tracks sequence
// time since release rather than FSM states.
module tb_sopc_rst_ctrl;

    localparam int RST_HOLD  = 4;
    localparam int MEM_LEAD  = 2;
    localparam int CNT_W     = 6;
    localparam int WDT_LIMIT = 50;
    localparam int MAXV      = (1 << CNT_W) - 1;
`ifdef SOPC_RST_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    typedef struct packed {
        logic             mem;
        logic             cpu;
        logic             stall;
        logic             halted;
        logic             wdt;
        logic [CNT_W-1:0] runc;
        logic [2:0]       state;
    } obs_t;

    logic             clk;
    logic             rst;
    logic             soft_rst_i;
    logic             halt_req_i;
    logic             mem_rst_o;
    logic             cpu_rst_o;
    logic             cpu_stall_o;
    logic             halted_o;
    logic             wdt_fired_o;
    logic [CNT_W-1:0] run_cycles_o;
    logic [2:0]       state_o;

    sopc_rst_ctrl #(
        .RST_HOLD  (RST_HOLD),
        .MEM_LEAD  (MEM_LEAD),
        .CNT_W     (CNT_W),
        .WDT_LIMIT (WDT_LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_i   (soft_rst_i),
        .halt_req_i   (halt_req_i),
        .mem_rst_o    (mem_rst_o),
        .cpu_rst_o    (cpu_rst_o),
        .cpu_stall_o  (cpu_stall_o),
        .halted_o     (halted_o),
        .wdt_fired_o  (wdt_fired_o),
        .run_cycles_o (run_cycles_o),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    obs_t exp_q[$];
    event chk_ev;

    // Reference model: edges since release, then time into the sequence.
    bit started;
    int rel;
    int seq;
    bit m_halted;
    bit m_wdt;
    int runc;

    function automatic void m_reset();
        started  = 0;
        rel      = 0;
        seq      = 0;
        m_halted = 0;
        m_wdt    = 0;
        runc     = 0;
    endfunction

    function automatic bit m_running();
        return started && !m_halted && seq >= RST_HOLD + MEM_LEAD;
    endfunction

    function automatic void m_edge(bit r, bit s, bit h);
        if (r) begin
            m_reset();
        end else if (!started) begin
            rel++;
            if (rel >= 3) begin
                started = 1;
                seq     = 0;
                runc    = 0;
            end
        end else if (s) begin
            seq      = 0;
            runc     = 0;
            m_halted = 0;
            m_wdt    = 0;
        end else if (m_halted) begin
            runc = runc;
        end else if (seq < RST_HOLD + MEM_LEAD) begin
            seq++;
        end else begin
            if (runc < MAXV) runc++;
            if (WDT_ON && runc == WDT_LIMIT) begin
                m_halted = 1;
                m_wdt    = 1;
            end else if (runc == MAXV || h) begin
                m_halted = 1;
            end
        end
    endfunction

    function automatic obs_t m_expect();
        obs_t e;
        e.mem    = !started || seq < RST_HOLD;
        e.cpu    = !started || seq < RST_HOLD + MEM_LEAD;
        e.stall  = m_halted;
        e.halted = m_halted;
        e.wdt    = m_wdt;
        e.runc   = CNT_W'(runc);
        if (!started)                          e.state = 3'd0;
        else if (m_halted)                     e.state = 3'd4;
        else if (seq < RST_HOLD)               e.state = 3'd1;
        else if (seq < RST_HOLD + MEM_LEAD)    e.state = 3'd2;
        else                                   e.state = 3'd3;
        return e;
    endfunction

    task automatic cyc(input bit s, input bit h);
        soft_rst_i = s;
        halt_req_i = h;
        @(posedge clk);
        m_edge(rst, s, h);
        exp_q.push_back(m_expect());
        #2;
    endtask

    // Mid-cycle 5 ns pulse; checked while rst is still high.
    task automatic rst_pulse();
        #10;
        rst = 1'b1;
        m_reset();
        exp_q.push_back(m_expect());
        #2;
        -> chk_ev;
        #3;
        rst = 1'b0;
    endtask

    task automatic timeout(input string what);
        vectors++;
        miscompares++;
        $display("FAIL timeout %s", what);
    endtask

    task automatic wait_run(input int budget);
        for (int i = 0; i < budget && !m_running(); i++) cyc(0, 0);
        if (!m_running()) timeout("wait_run");
    endtask

    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk or chk_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{mem_rst_o, cpu_rst_o, cpu_stall_o, halted_o,
                      wdt_fired_o, run_cycles_o, state_o};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d t=%0t got mem=%b cpu=%b stall=%b halt=%b wdt=%b run=%0d st=%0d want mem=%b cpu=%b stall=%b halt=%b wdt=%b run=%0d st=%0d",
                             vectors, $time, a.mem, a.cpu, a.stall, a.halted,
                             a.wdt, a.runc, a.state, e.mem, e.cpu, e.stall,
                             e.halted, e.wdt, e.runc, e.state);
                end
            end
        end
    end

    initial begin : stim
        rst        = 1'b1;
        soft_rst_i = 1'b0;
        halt_req_i = 1'b0;
        m_reset();

        // Power-up: edges at 10..190 under rst, release at 195 ns.
        repeat (10) cyc(0, 0);
        #3;
        rst = 1'b0;
        repeat (14) cyc(0, 0);

        // Halt request landing when the count reaches 20, then soft reset.
        for (int i = 0; i < 100 && !(m_running() && runc == 19); i++)
            cyc(0, 0);
        if (!(m_running() && runc == 19)) timeout("run19");
        cyc(0, 1);
        repeat (4) cyc(0, 1);
        cyc(1, 0);
        repeat (3) cyc(0, 0);

        // Soft reset and halt request in the same RUN cycle.
        wait_run(50);
        repeat (3) cyc(0, 0);
        cyc(1, 1);
        repeat (3) cyc(0, 0);

        // Long run: watchdog halt at 50, or saturation at 63 without it.
        wait_run(50);
        for (int i = 0; i < 200 && !m_halted; i++) cyc(0, 0);
        if (!m_halted) timeout("long_run_halt");
        repeat (5) cyc(0, 1);

        // Async reset pulse mid-RUN and full resequence.
        cyc(1, 0);
        wait_run(50);
        repeat (5) cyc(0, 0);
        rst_pulse();
        repeat (16) cyc(0, 0);

        // Randomized traffic with occasional async pulses.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) rst_pulse();
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
